// File: rtl/minterm_pkg.sv
// ============================================================================
// Module   : minterm_pkg
// Purpose  : Shared FSM encoding and N_VARS legal range for minterm_sweeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package minterm_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SWEEP = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam int c_N_VARS_MIN = 1;
    localparam int c_N_VARS_MAX = 8;

endpackage : minterm_pkg

`default_nettype wire

// File: rtl/minterm_lut.sv
// ============================================================================
// Module   : minterm_lut
// Purpose  : Combinational mask lookup; optional maxterm inversion under
//            MINTERM_SWEEPER_MAXTERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minterm_lut #(
    parameter int N_VARS = 4,
    localparam int MASK_W = 2 ** N_VARS
) (
    input  logic [MASK_W-1:0] mask,
    input  logic [N_VARS-1:0] index,
`ifdef MINTERM_SWEEPER_MAXTERM_EN
    input  logic              invert,
`endif
    output logic              bit_out
);

`ifdef MINTERM_SWEEPER_MAXTERM_EN
    // A maxterm list marks the zeros of the function, so the looked-up bit flips.
    assign bit_out = mask[index] ^ invert;
`else
    assign bit_out = mask[index];
`endif

endmodule : minterm_lut

`default_nettype wire

// File: rtl/minterm_sweeper.sv
// ============================================================================
// Module   : minterm_sweeper
// Purpose  : Sweeps all 2^N_VARS input combinations of a mask-defined Boolean
//            function and counts its true points. Optional maxterm mode is
//            enabled by the macro MINTERM_SWEEPER_MAXTERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minterm_sweeper
    import minterm_pkg::*;
#(
    parameter int N_VARS = 4,
    localparam int MASK_W = 2 ** N_VARS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MASK_W-1:0] mask,
`ifdef MINTERM_SWEEPER_MAXTERM_EN
    input  logic              maxterm_mode,
`endif
    input  logic              out_ready,
    output logic              busy,
    output logic              valid,
    output logic [N_VARS-1:0] vars,
    output logic              f_out,
    output logic              done,
    output logic [N_VARS:0]   ones_count
);

    localparam logic [N_VARS-1:0] c_LAST_IDX = '1;

    generate
        if (N_VARS < c_N_VARS_MIN || N_VARS > c_N_VARS_MAX) begin : g_bad_n_vars
            $error("minterm_sweeper: N_VARS out of range");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [N_VARS-1:0] r_vars;
    logic [N_VARS:0]   r_ones;
    logic [MASK_W-1:0] r_mask;
    logic              w_bit;
    logic              w_accept;
`ifdef MINTERM_SWEEPER_MAXTERM_EN
    logic              r_maxterm;
`endif

    minterm_lut #(
        .N_VARS (N_VARS)
    ) u_lut (
        .mask    (r_mask),
        .index   (r_vars),
`ifdef MINTERM_SWEEPER_MAXTERM_EN
        .invert  (r_maxterm),
`endif
        .bit_out (w_bit)
    );

    assign w_accept = (r_state == c_ST_SWEEP) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_vars  <= '0;
            r_ones  <= '0;
            r_mask  <= '0;
`ifdef MINTERM_SWEEPER_MAXTERM_EN
            r_maxterm <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mask  <= mask;
`ifdef MINTERM_SWEEPER_MAXTERM_EN
                        r_maxterm <= maxterm_mode;
`endif
                        r_ones  <= '0;
                        r_vars  <= '0;
                        r_state <= c_ST_SWEEP;
                    end
                end
                c_ST_SWEEP: begin
                    if (w_accept) begin
                        r_ones <= r_ones + {{N_VARS{1'b0}}, w_bit};
                        // Index parks on the last combination rather than wrapping.
                        if (r_vars == c_LAST_IDX) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_vars <= r_vars + 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_ST_IDLE);
    assign valid      = (r_state == c_ST_SWEEP);
    assign done       = (r_state == c_ST_DONE);
    assign vars       = r_vars;
    assign f_out      = valid & w_bit;
    assign ones_count = r_ones;

endmodule : minterm_sweeper

`default_nettype wire

// File: tb/tb_minterm_sweeper.sv
// ============================================================================
// Module   : tb_minterm_sweeper
// Purpose  : Randomised self-checking bench for minterm_sweeper (N_VARS 4 and 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minterm_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, out_ready, maxterm_mode;
    logic [15:0] mask;
    logic        busy, valid, f_out, done;
    logic [3:0]  vars;
    logic [4:0]  ones_count;

    logic        start2, ready2;
    logic [3:0]  mask2;
    logic        busy2, valid2, f2, done2;
    logic [1:0]  vars2;
    logic [2:0]  ones2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minterm_sweeper #(.N_VARS(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mask       (mask),
`ifdef MINTERM_SWEEPER_MAXTERM_EN
        .maxterm_mode (maxterm_mode),
`endif
        .out_ready  (out_ready),
        .busy       (busy),
        .valid      (valid),
        .vars       (vars),
        .f_out      (f_out),
        .done       (done),
        .ones_count (ones_count)
    );

    minterm_sweeper #(.N_VARS(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start2),
        .mask       (mask2),
`ifdef MINTERM_SWEEPER_MAXTERM_EN
        .maxterm_mode (1'b0),
`endif
        .out_ready  (ready2),
        .busy       (busy2),
        .valid      (valid2),
        .vars       (vars2),
        .f_out      (f2),
        .done       (done2),
        .ones_count (ones2)
    );

    task automatic check_eq(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: beat k carries f = bit k of the latched mask (inverted in maxterm mode).
    // stall_mode 1 drives random out_ready; chg_at/rst_at disturb the sweep at that index.
    task automatic sweep(input logic [15:0] m, input bit mx, input int stall_mode,
                         input int chg_at, input int rst_at, output int ones_out);
        logic [15:0] lm;
        int idx, ones, cyc, exp_f;
        bit rdy, finished;
        lm = m;
        idx = 0; ones = 0; cyc = 0; finished = 0;
        mask = m; maxterm_mode = mx; start = 1'b1;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (!finished && cyc < 300) begin
            exp_f = int'(lm[idx]) ^ int'(mx);
            check_eq("beat_valid", int'(valid), 1);
            check_eq("beat_vars", int'(vars), idx);
            check_eq("beat_f", int'(f_out), exp_f);
            check_eq("beat_ones", int'(ones_count), ones);
            if (idx == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq("rst_valid", int'(valid), 0);
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_vars", int'(vars), 0);
                check_eq("rst_ones", int'(ones_count), 0);
                ones_out = 0;
                return;
            end
            if (idx == chg_at) mask = 16'hFFFF;
            rdy = (stall_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = rdy;
            @(negedge clk); cyc++;
            if (rdy) begin
                ones += exp_f;
                if (idx == 15) finished = 1;
                else idx++;
            end
        end
        check_eq("sweep_timeout", int'(finished), 1);
        out_ready = 1'b1;
        check_eq("done_pulse", int'(done), 1);
        check_eq("done_busy", int'(busy), 1);
        check_eq("done_valid", int'(valid), 0);
        check_eq("done_ones", int'(ones_count), ones);
        check_eq("done_popcount", ones, mx ? 16 - $countones(lm) : $countones(lm));
        if (stall_mode == 0) check_eq("done_latency", cyc, 17);
        @(negedge clk);
        check_eq("idle_done", int'(done), 0);
        check_eq("idle_busy", int'(busy), 0);
        check_eq("idle_valid", int'(valid), 0);
        check_eq("idle_ones_hold", int'(ones_count), ones);
        ones_out = ones;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; maxterm_mode = 1'b0; mask = '0;
        start2 = 1'b0; ready2 = 1'b1; mask2 = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_valid", int'(valid), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_vars", int'(vars), 0);
        check_eq("reset_f", int'(f_out), 0);
        check_eq("reset_ones", int'(ones_count), 0);
        check_eq("reset2_busy", int'(busy2), 0);

        sweep(16'h230D, 1'b0, 0, -1, -1, n);
        check_eq("s1_ones", n, 6);
        sweep(16'h230D, 1'b0, 1, -1, -1, n);
        check_eq("s2_ones", n, 6);
        sweep(16'h230D, 1'b0, 0, 5, -1, n);
        check_eq("s3_ones", n, 6);
        sweep(16'h230D, 1'b0, 0, -1, 9, n);
        sweep(16'h230D, 1'b0, 0, -1, -1, n);
        check_eq("s4_ones", n, 6);

        for (int k = 0; k < 6; k++) begin
            sweep(16'($urandom), 1'b0, int'($urandom_range(0, 1)), -1, -1, n);
        end
        sweep(16'h0000, 1'b0, 0, -1, -1, n);
        check_eq("zero_ones", n, 0);
        sweep(16'hFFFF, 1'b0, 1, -1, -1, n);
        check_eq("full_ones", n, 16);

`ifdef MINTERM_SWEEPER_MAXTERM_EN
        sweep(16'h230D, 1'b1, 0, -1, -1, n);
        check_eq("s6_ones", n, 10);
        sweep(16'($urandom), 1'b1, 1, -1, -1, n);
`endif

        // Small instance with start held high: back-to-back passes through IDLE.
        start2 = 1'b1; ready2 = 1'b1; mask2 = 4'hF;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check_eq("s5_valid", int'(valid2), 1);
                check_eq("s5_vars", int'(vars2), i);
                check_eq("s5_f", int'(f2), 1);
                check_eq("s5_ones_run", int'(ones2), i);
            end
            @(negedge clk);
            check_eq("s5_done", int'(done2), 1);
            check_eq("s5_ones", int'(ones2), 4);
            @(negedge clk);
            check_eq("s5_idle_valid", int'(valid2), 0);
            check_eq("s5_idle_busy", int'(busy2), 0);
            check_eq("s5_idle_ones", int'(ones2), 4);
        end
        start2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_minterm_sweeper

`default_nettype wire
